// File: rtl/rr_mux_arb.sv
// rr_mux_arb
//   N:1 registered data multiplexer with valid/ready handshakes on every
//   input channel and on the output. One channel is granted per cycle,
//   either by round-robin arbitration or by a fixed select. The chosen word
//   is registered together with its channel index.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   din               CHANNELS*WIDTH packed input words, channel i at [i*WIDTH +: WIDTH]
//   din_valid/ready   per-channel handshake (din_ready is one-hot or zero)
//   mode              0 = round-robin, 1 = fixed select on s
//   s                 fixed-mode channel select
//   dout, dout_ch     registered output word and its channel index
//   dout_valid/ready  output handshake
//   din_last/dout_last  packet framing, present only with RR_MUX_LAST_EN
//
// Optional feature macro: RR_MUX_LAST_EN
//   When defined, a transfer with din_last=0 locks the grant to that channel
//   until a transfer on it with din_last=1.

module rr_mux_arb #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 8,
  parameter int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       din_valid,
  output logic [CHANNELS-1:0]       din_ready,
  input  logic                      mode,
  input  logic [SW-1:0]             s,
  output logic [WIDTH-1:0]          dout,
  output logic [SW-1:0]             dout_ch,
  output logic                      dout_valid,
  input  logic                      dout_ready
`ifdef RR_MUX_LAST_EN
  ,
  input  logic [CHANNELS-1:0]       din_last,
  output logic                      dout_last
`endif
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SW-1:0]    doutCh_q, doutCh_d;
  logic             doutValid_q, doutValid_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic             xfer;
  logic             locked;
  logic [SW-1:0]    lockCh;
  logic             lockFound;
  logic             rrFound;
  logic [SW-1:0]    rrGrant;
  logic             fixFound;
  logic             candFound;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    nextPtr;
  logic [WIDTH-1:0] selData;

  assign load    = !doutValid_q || dout_ready;
  assign xfer    = rst_n && load && candFound;
  assign nextPtr = (int'(grant) == CHANNELS - 1) ? '0 : grant + SW'(1);

  // Round-robin search in two passes: first the channels at or above the
  // pointer, then wrap around to the ones below it.
  always_comb begin
    rrFound = 1'b0;
    rrGrant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rrFound && din_valid[i] && (i >= int'(ptr_q))) begin
        rrFound = 1'b1;
        rrGrant = SW'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rrFound && din_valid[i]) begin
        rrFound = 1'b1;
        rrGrant = SW'(i);
      end
    end
  end

  // Fixed and locked candidates are found by comparison so that an
  // out-of-range select simply matches nothing.
  always_comb begin
    fixFound  = 1'b0;
    lockFound = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (din_valid[i] && (int'(s) == i)) fixFound = 1'b1;
      if (din_valid[i] && (int'(lockCh) == i)) lockFound = 1'b1;
    end
  end

  // A held lock overrides both arbitration modes.
  always_comb begin
    candFound = 1'b0;
    grant     = '0;
    if (locked) begin
      candFound = lockFound;
      grant     = lockCh;
    end else if (mode) begin
      candFound = fixFound;
      grant     = s;
    end else begin
      candFound = rrFound;
      grant     = rrGrant;
    end
  end

  always_comb begin
    din_ready = '0;
    selData   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grant) == i) begin
        din_ready[i] = xfer;
        selData      = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register next state: hold on stall, drop valid when a load slot
  // goes unused. The pointer only moves on unlocked round-robin grants.
  always_comb begin
    dout_d      = dout_q;
    doutCh_d    = doutCh_q;
    doutValid_d = doutValid_q;
    ptr_d       = ptr_q;
    if (load) begin
      doutValid_d = xfer;
      if (xfer) begin
        dout_d   = selData;
        doutCh_d = grant;
        if (!locked && !mode) ptr_d = nextPtr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q      <= '0;
      doutCh_q    <= '0;
      doutValid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      dout_q      <= dout_d;
      doutCh_q    <= doutCh_d;
      doutValid_q <= doutValid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_ch    = doutCh_q;
  assign dout_valid = doutValid_q;

`ifdef RR_MUX_LAST_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lockCh_q, lockCh_d;
  logic          doutLast_q, doutLast_d;
  logic          selLast;

  always_comb begin
    selLast = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grant) == i) selLast = din_last[i];
    end
  end

  // Every transfer re-evaluates the lock: a non-last beat holds the grant
  // on its channel, a last beat releases it.
  always_comb begin
    lock_d     = lock_q;
    lockCh_d   = lockCh_q;
    doutLast_d = doutLast_q;
    if (xfer) begin
      lock_d     = !selLast;
      lockCh_d   = grant;
      doutLast_d = selLast;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lockCh_q   <= '0;
      doutLast_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lockCh_q   <= lockCh_d;
      doutLast_q <= doutLast_d;
    end
  end

  assign locked    = lock_q;
  assign lockCh    = lockCh_q;
  assign dout_last = doutLast_q;
`else
  assign locked = 1'b0;
  assign lockCh = '0;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb
//   Directed bench for rr_mux_arb (CHANNELS=6, WIDTH=8). Each step drives the
//   inputs, checks din_ready against the grant expected for that step, pushes
//   the expected output word into a queue, and after the clock edge compares
//   the registered outputs against the head of that queue.

module tb_rr_mux_arb;

  localparam int CHANNELS = 6;
  localparam int WIDTH    = 8;
  localparam int SW       = $clog2(CHANNELS);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    ch;
    logic             last;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CHANNELS*WIDTH-1:0] din = '0;
  logic [CHANNELS-1:0]       din_valid = '0;
  logic [CHANNELS-1:0]       din_ready;
  logic                      mode = 1'b0;
  logic [SW-1:0]             s = '0;
  logic [WIDTH-1:0]          dout;
  logic [SW-1:0]             dout_ch;
  logic                      dout_valid;
  logic                      dout_ready = 1'b0;
  logic [CHANNELS-1:0]       din_last = '0;
`ifdef RR_MUX_LAST_EN
  logic                      dout_last;
`endif

  beat_t               expQ[$];
  int                  nVectors = 0;
  int                  nFail = 0;
  logic [WIDTH-1:0]    dataBase = 8'h10;
  logic [CHANNELS-1:0] lastVec = '0;

  rr_mux_arb #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .mode       (mode),
    .s          (s),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef RR_MUX_LAST_EN
    ,
    .din_last   (din_last),
    .dout_last  (dout_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic driveData();
    for (int i = 0; i < CHANNELS; i++) din[i*WIDTH +: WIDTH] = dataBase + WIDTH'(i);
  endtask

  // Registered outputs must match the oldest outstanding expected word, or
  // show no valid word when nothing is outstanding.
  task automatic checkOutput();
    if (expQ.size() == 0) begin
      checkValue("dout_valid_idle", 32'(dout_valid), 32'd0);
    end else begin
      checkValue("dout_valid", 32'(dout_valid), 32'd1);
      checkValue("dout", 32'(dout), 32'(expQ[0].data));
      checkValue("dout_ch", 32'(dout_ch), 32'(expQ[0].ch));
`ifdef RR_MUX_LAST_EN
      checkValue("dout_last", 32'(dout_last), 32'(expQ[0].last));
`endif
    end
  endtask

  // One clock of stimulus. expGrant is the channel the arbitration should
  // pick for these inputs (-1 for none); it only turns into din_ready when
  // the output register can load.
  task automatic applyStimulus(input logic [CHANNELS-1:0] valid, input logic m,
                               input logic [SW-1:0] sel, input logic rdy, input int expGrant);
    logic                load;
    logic                pop;
    logic [CHANNELS-1:0] expReady;
    beat_t               b;
    din_valid  = valid;
    mode       = m;
    s          = sel;
    dout_ready = rdy;
    din_last   = lastVec;
    driveData();
    #1;
    load = (expQ.size() == 0) || rdy;
    for (int i = 0; i < CHANNELS; i++) expReady[i] = load && (i == expGrant);
    checkValue("din_ready", 32'(din_ready), 32'(expReady));
    pop = (expQ.size() != 0) && rdy;
    @(posedge clk);
    if (pop) void'(expQ.pop_front());
    if (expReady != '0) begin
      b.data = dataBase + WIDTH'(expGrant);
      b.ch   = SW'(expGrant);
      b.last = lastVec[expGrant];
      expQ.push_back(b);
    end
    #1;
    checkOutput();
  endtask

  task automatic resetCycle();
    rst_n      = 1'b0;
    din_valid  = '1;
    dout_ready = 1'b1;
    mode       = 1'b0;
    s          = '0;
    driveData();
    #1;
    checkValue("din_ready_rst", 32'(din_ready), 32'd0);
    @(posedge clk);
    expQ.delete();
    #1;
    checkValue("dout_valid_rst", 32'(dout_valid), 32'd0);
    checkValue("dout_rst", 32'(dout), 32'd0);
    checkValue("dout_ch_rst", 32'(dout_ch), 32'd0);
  endtask

  initial begin
    $display("[TB] rr_mux_arb directed run");

    resetCycle();
    resetCycle();
    rst_n = 1'b1;

    // Fairness with every channel valid
    for (int g = 0; g < CHANNELS; g++) applyStimulus('1, 1'b0, '0, 1'b1, g);
    applyStimulus('1, 1'b0, '0, 1'b1, 0);

    // Park the pointer at 5, then skip and wrap between channels 1 and 4
    applyStimulus(6'b010000, 1'b0, '0, 1'b1, 4);
    applyStimulus(6'b010010, 1'b0, '0, 1'b1, 1);
    applyStimulus(6'b010010, 1'b0, '0, 1'b1, 4);
    applyStimulus(6'b010010, 1'b0, '0, 1'b1, 1);

    // Backpressure on a registered word from channel 2
    applyStimulus(6'b000100, 1'b0, '0, 1'b1, 2);
    dataBase = 8'h20;
    for (int k = 0; k < 3; k++) applyStimulus(6'b000100, 1'b0, '0, 1'b0, 2);
    applyStimulus(6'b000100, 1'b0, '0, 1'b1, 2);

    // Fixed select, then an out-of-range select drains the output
    applyStimulus('1, 1'b1, 3'd3, 1'b1, 3);
    applyStimulus('1, 1'b1, 3'd3, 1'b1, 3);
    applyStimulus('1, 1'b1, 3'd7, 1'b1, -1);
    checkValue("dout_hold", 32'(dout), 32'h23);
    checkValue("dout_ch_hold", 32'(dout_ch), 32'd3);
    applyStimulus('1, 1'b1, 3'd7, 1'b1, -1);

    // Fixed grants left the pointer at 3
    applyStimulus('1, 1'b0, '0, 1'b1, 3);
    applyStimulus('1, 1'b0, '0, 1'b1, 4);

    // Reset in the middle of a stream discards the word and the pointer
    resetCycle();
    rst_n = 1'b1;
    applyStimulus('1, 1'b0, '0, 1'b1, 0);
    applyStimulus('0, 1'b0, '0, 1'b1, -1);

`ifdef RR_MUX_LAST_EN
    // Three-beat packet on channel 0 holds off channel 1, even in fixed mode
    resetCycle();
    rst_n   = 1'b1;
    lastVec = 6'b000000;
    applyStimulus(6'b000011, 1'b0, '0, 1'b1, 0);
    applyStimulus(6'b000011, 1'b1, 3'd5, 1'b1, 0);
    lastVec = 6'b000001;
    applyStimulus(6'b000011, 1'b0, '0, 1'b1, 0);
    lastVec = 6'b000000;
    applyStimulus(6'b000011, 1'b0, '0, 1'b1, 1);
    applyStimulus('0, 1'b0, '0, 1'b1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

endmodule
